alu_cmd_sequencer: RTL and testbench
====================================

ALU_CMD_SEQUENCER -- requirements
Module: alu_cmd_sequencer

Interface
REQ-001 Parameter: DEPTH, default 4, command FIFO entries; power of two, 2..16.
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: cmd_valid  input  1  upstream command valid.
REQ-005 Port: cmd_ready  output  1  FIFO can accept a command.
REQ-006 Port: cmd_opcode  input  4  ALU opcode: 0 hold, 1 add, 2 sub (B-A), 3 mul, 4 div (B/A), 5 rem (B%A), 6-14 logic/shift, 15 zero.
REQ-007 Port: cmd_a  input  32  operand A.
REQ-008 Port: cmd_b  input  32  operand B.
REQ-009 Port: alu_opcode  output  4  opcode driven to the ALU; registered.
REQ-010 Port: alu_a  output  32  operand A driven to the ALU; registered.
REQ-011 Port: alu_b  output  32  operand B driven to the ALU; registered.
REQ-012 Port: alu_c  input  32  ALU accumulator output; valid one cycle after issue.
REQ-013 Port: alu_err  input  1  ALU registered carry flag; valid one cycle after issue.
REQ-014 Port: rsp_valid  output  1  response valid.
REQ-015 Port: rsp_ready  input  1  downstream accepts response.
REQ-016 Port: rsp_data  output  32  result.
REQ-017 Port: rsp_err  output  1  add carry-out.
REQ-018 Port: rsp_dz  output  1  divide/remainder by zero.
REQ-019 Port: count  output  $clog2(DEPTH)+1  FIFO occupancy.
REQ-020 Port: busy  output  1  high whenever state is not IDLE.

Function
REQ-021 Command accept: cmd_valid && cmd_ready at a rising edge; entry {opcode,a,b} written to FIFO tail.
REQ-022 cmd_ready SHALL be !full; no pass-through when full, even if a pop occurs in the same cycle.
REQ-023 Simultaneous push and pop: count unchanged; the command order is preserved.
REQ-024 FSM states: IDLE, ISSUE, WAIT, RESP; encoding is free.
REQ-025 IDLE: if count > 0, pop the head into the issue registers and go to ISSUE; otherwise stay in IDLE.
REQ-026 ISSUE, one cycle: alu_opcode/alu_a/alu_b present the popped command; next state is WAIT.
REQ-027 Divide-by-zero check: opcode 4 or 5 with a == 0 sets the dz flag at pop.
  - In ISSUE, alu_opcode is forced to 0 so the ALU holds its accumulator.
REQ-028 WAIT, one cycle: capture the response registers at the edge, then go to RESP.
  - rsp_data = alu_c, or 32'hFFFFFFFF when dz.
  - rsp_err = alu_err && opcode == 1 && !dz.
  - rsp_dz = dz.
REQ-029 RESP: rsp_valid = 1. While rsp_ready = 0, rsp_data/rsp_err/rsp_dz are held stable.
REQ-030 RESP with rsp_ready = 1: if count > 0, pop and go to ISSUE (no IDLE bubble); otherwise go to IDLE.
REQ-031 Outside ISSUE, alu_opcode = 0; alu_a and alu_b keep their last values.
REQ-032 Latency: accept at edge E0 -> pop at E1 (from IDLE) -> rsp_valid high after E3.
REQ-033 Throughput: at most one response every 3 cycles; responses are returned in command order.
REQ-034 No arithmetic is performed in this block; all widths pass through at 32 bits.
REQ-035 FIFO pointers wrap modulo DEPTH; count saturates at neither end, because push is blocked when full and pop is blocked when empty.

Reset
REQ-036 On reset = 1 at an edge, the following SHALL take effect on the next cycle:
  - state IDLE; FIFO emptied (count = 0, pointers = 0).
  - cmd_ready = 1; busy = 0; rsp_valid = 0.
  - rsp_data = 0, rsp_err = 0, rsp_dz = 0.
  - alu_opcode = 0, alu_a = 0, alu_b = 0.
REQ-037 Reset mid-operation (ISSUE, WAIT or RESP) discards both the in-flight command and the queued commands; no response is produced for them.
REQ-038 A command presented during a reset cycle is not accepted.

Verification
REQ-039 Add: opcode 1, a = 5, b = 7 accepted at E0 -> rsp_valid after E3; rsp_data = 12, rsp_err = 0, rsp_dz = 0.
REQ-040 Carry: opcode 1, a = 32'hFFFFFFFF, b = 1 -> rsp_data = 0, rsp_err = 1.
REQ-041 Divide by zero:
  - opcode 4, a = 0, b = 100 -> rsp_data = 32'hFFFFFFFF, rsp_dz = 1, and alu_opcode stays 0 throughout.
  - opcode 5, a = 3, b = 100 -> rsp_data = 1, rsp_dz = 0.
REQ-042 Full FIFO: rsp_ready = 0, six back-to-back sub commands (a = i, b = 10) ->
  - cmd_ready falls after the 5th accept.
  - the 6th command is accepted after the first response is consumed.
  - responses arrive as 10, 9, 8, 7, 6, 5, in that order.
REQ-043 Backpressure: hold rsp_ready = 0 for 10 cycles in RESP -> rsp_data and rsp_valid are stable; then rsp_ready = 1 for one cycle -> the next queued command enters ISSUE on the following cycle.
REQ-044 Reset in WAIT with 2 entries queued -> next cycle: count = 0, rsp_valid = 0, busy = 0, cmd_ready = 1, alu_opcode = 0; no response appears afterwards.

Source files
------------

// File: rtl/alu_cmd_sequencer.sv
// Queues ALU commands in a small FIFO and sequences each through the ALU:
// issue, one wait cycle for the registered result, then a held response.
module alu_cmd_sequencer #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [3:0]               cmd_opcode,
    input  logic [31:0]              cmd_a,
    input  logic [31:0]              cmd_b,
    output logic [3:0]               alu_opcode,
    output logic [31:0]              alu_a,
    output logic [31:0]              alu_b,
    input  logic [31:0]              alu_c,
    input  logic                     alu_err,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [31:0]              rsp_data,
    output logic                     rsp_err,
    output logic                     rsp_dz,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int DATA_W = 32;
    localparam logic [3:0] OP_HOLD = 4'd0;
    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_DIV  = 4'd4;
    localparam logic [3:0] OP_REM  = 4'd5;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    function automatic logic is_div_by_zero(input logic [3:0] op, input logic [DATA_W-1:0] a);
        return ((op == OP_DIV) || (op == OP_REM)) && (a == '0);
    endfunction

    state_t              state_q, state_d;
    logic [3:0]          mem_op [DEPTH];
    logic [DATA_W-1:0]   mem_a  [DEPTH];
    logic [DATA_W-1:0]   mem_b  [DEPTH];
    logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]       count_q, count_d;
    logic                full, empty, push, pop;
    logic [3:0]          head_op;
    logic [DATA_W-1:0]   head_a, head_b;
    logic                head_dz;
    logic [3:0]          op_q;
    logic                dz_q;
    logic [3:0]          alu_opcode_q;
    logic [DATA_W-1:0]   alu_a_q, alu_b_q;
    logic [DATA_W-1:0]   rsp_data_q;
    logic                rsp_err_q, rsp_dz_q;

    assign full      = (count_q == CW'(DEPTH));
    assign empty     = (count_q == '0);
    assign cmd_ready = !full;
    assign push      = cmd_valid && !full;

    assign head_op = mem_op[rd_ptr_q];
    assign head_a  = mem_a[rd_ptr_q];
    assign head_b  = mem_b[rd_ptr_q];
    assign head_dz = is_div_by_zero(head_op, head_a);

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (!push && pop) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
        end
    end

    // Storage carries no reset; occupancy and pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push && !reset) begin
            mem_op[wr_ptr_q] <= cmd_opcode;
            mem_a[wr_ptr_q]  <= cmd_a;
            mem_b[wr_ptr_q]  <= cmd_b;
        end
    end

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: state_d = WAIT;
            WAIT:  state_d = RESP;
            RESP: begin
                if (rsp_ready) begin
                    if (!empty) begin
                        pop     = 1'b1;
                        state_d = ISSUE;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A zero divisor issues a hold so the ALU accumulator is left untouched.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_q         <= OP_HOLD;
            dz_q         <= 1'b0;
            alu_opcode_q <= OP_HOLD;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            rsp_data_q   <= '0;
            rsp_err_q    <= 1'b0;
            rsp_dz_q     <= 1'b0;
        end else begin
            alu_opcode_q <= OP_HOLD;
            if (pop) begin
                op_q         <= head_op;
                dz_q         <= head_dz;
                alu_opcode_q <= head_dz ? OP_HOLD : head_op;
                alu_a_q      <= head_a;
                alu_b_q      <= head_b;
            end
            if (state_q == WAIT) begin
                rsp_data_q <= dz_q ? '1 : alu_c;
                rsp_err_q  <= alu_err && (op_q == OP_ADD) && !dz_q;
                rsp_dz_q   <= dz_q;
            end
        end
    end

    assign alu_opcode = alu_opcode_q;
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign rsp_valid  = (state_q == RESP);
    assign rsp_data   = rsp_data_q;
    assign rsp_err    = rsp_err_q;
    assign rsp_dz     = rsp_dz_q;
    assign count      = count_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Testbench for alu_cmd_sequencer: a behavioural ALU answers issued commands and
// a scoreboard queue holds the expected response of every accepted command.
module tb_alu_cmd_sequencer;

    localparam int DEPTH = 4;
    localparam int CW = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [3:0]    cmd_opcode = '0;
    logic [31:0]   cmd_a = '0;
    logic [31:0]   cmd_b = '0;
    logic [3:0]    alu_opcode;
    logic [31:0]   alu_a, alu_b;
    logic [31:0]   alu_c = '0;
    logic          alu_err = 1'b0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [31:0]   rsp_data;
    logic          rsp_err, rsp_dz;
    logic [CW-1:0] count;
    logic          busy;

    int errors = 0;
    int checks = 0;
    int unsigned cyc = 0;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
        logic        dz;
    } exp_t;
    exp_t sbq[$];

    alu_cmd_sequencer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_opcode(cmd_opcode), .cmd_a(cmd_a), .cmd_b(cmd_b),
        .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
        .alu_c(alu_c), .alu_err(alu_err),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_err(rsp_err), .rsp_dz(rsp_dz),
        .count(count), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural ALU: registered accumulator and carry, opcode 0 holds.
    always @(posedge clk) begin
        case (alu_opcode)
            4'd0: ;
            4'd1: {alu_err, alu_c} <= {1'b0, alu_a} + {1'b0, alu_b};
            4'd2: begin alu_c <= alu_b - alu_a; alu_err <= 1'b0; end
            4'd3: begin alu_c <= alu_a * alu_b; alu_err <= 1'b0; end
            4'd4: begin alu_c <= (alu_a == 0) ? 32'h0BAD0BAD : alu_b / alu_a; alu_err <= 1'b0; end
            4'd5: begin alu_c <= (alu_a == 0) ? 32'h0BAD0BAD : alu_b % alu_a; alu_err <= 1'b0; end
            4'd15: begin alu_c <= '0; alu_err <= 1'b0; end
            default: begin alu_c <= alu_a ^ alu_b; alu_err <= 1'b0; end
        endcase
    end

    function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        logic [32:0] s;
        e = '0;
        s = {1'b0, a} + {1'b0, b};
        case (op)
            4'd1: begin e.data = s[31:0]; e.err = s[32]; end
            4'd2: e.data = b - a;
            4'd3: e.data = a * b;
            4'd4: if (a == 0) begin e.data = '1; e.dz = 1'b1; end else e.data = b / a;
            4'd5: if (a == 0) begin e.data = '1; e.dz = 1'b1; end else e.data = b % a;
            default: e.data = a ^ b;
        endcase
        return e;
    endfunction

    // Called on a falling edge; returns on the falling edge after the accepting edge.
    task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int g = 0;
        cmd_opcode = op; cmd_a = a; cmd_b = b; cmd_valid = 1'b1;
        while (!cmd_ready && g < 200) begin @(negedge clk); g++; end
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL send_timeout: cmd_ready=%b required 1", cmd_ready);
        end else begin
            sbq.push_back(model(op, a, b));
        end
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp();
        int g = 0;
        while (!rsp_valid && g < 60) begin @(negedge clk); g++; end
        checks++;
        if (rsp_valid !== 1'b1) begin
            errors++;
            $display("FAIL rsp_timeout: rsp_valid=%b required 1", rsp_valid);
        end
    endtask

    task automatic ack();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({cmd_ready, busy, rsp_valid} !== 3'b100) begin
            errors++;
            $display("FAIL reset_ctrl: ready/busy/valid=%b%b%b required 100", cmd_ready, busy, rsp_valid);
        end
        checks++;
        if (count !== '0) begin errors++; $display("FAIL reset_count: got %0d required 0", count); end
        checks++;
        if ({rsp_data, rsp_err, rsp_dz} !== 34'd0) begin
            errors++;
            $display("FAIL reset_rsp: got %h/%b/%b required 0/0/0", rsp_data, rsp_err, rsp_dz);
        end
        checks++;
        if ({alu_opcode, alu_a, alu_b} !== 68'd0) begin
            errors++;
            $display("FAIL reset_alu: got op=%0d a=%h b=%h required 0", alu_opcode, alu_a, alu_b);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_add();
        exp_t e;
        send(4'd1, 32'd5, 32'd7);
        checks++;
        if (count !== CW'(1)) begin errors++; $display("FAIL add_count: got %0d required 1", count); end
        @(negedge clk);
        checks++;
        if ({alu_opcode, alu_a, alu_b} !== {4'd1, 32'd5, 32'd7}) begin
            errors++;
            $display("FAIL add_issue: got op=%0d a=%0d b=%0d required 1/5/7", alu_opcode, alu_a, alu_b);
        end
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0 || alu_opcode !== 4'd0) begin
            errors++;
            $display("FAIL add_wait: rsp_valid=%b alu_opcode=%0d required 0/0", rsp_valid, alu_opcode);
        end
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1) begin errors++; $display("FAIL add_latency: rsp_valid=%b required 1", rsp_valid); end
        e = sbq.pop_front();
        checks++;
        if ({rsp_data, rsp_err, rsp_dz} !== {e.data, e.err, e.dz}) begin
            errors++;
            $display("FAIL add_rsp: got %h/%b/%b required %h/%b/%b", rsp_data, rsp_err, rsp_dz, e.data, e.err, e.dz);
        end
        ack();
    endtask

    task automatic test_carry();
        exp_t e;
        send(4'd1, 32'hFFFFFFFF, 32'd1);
        wait_rsp();
        e = sbq.pop_front();
        checks++;
        if ({rsp_data, rsp_err, rsp_dz} !== {e.data, e.err, e.dz}) begin
            errors++;
            $display("FAIL carry_rsp: got %h/%b/%b required %h/%b/%b", rsp_data, rsp_err, rsp_dz, e.data, e.err, e.dz);
        end
        ack();
    endtask

    task automatic test_divzero();
        exp_t e;
        int g = 0;
        logic held = 1'b1;
        send(4'd4, 32'd0, 32'd100);
        while (!rsp_valid && g < 20) begin
            if (alu_opcode !== 4'd0) held = 1'b0;
            @(negedge clk);
            g++;
        end
        checks++;
        if (held !== 1'b1) begin errors++; $display("FAIL dz_hold: alu_opcode left 0, required 0 throughout"); end
        wait_rsp();
        e = sbq.pop_front();
        checks++;
        if ({rsp_data, rsp_err, rsp_dz} !== {e.data, e.err, e.dz}) begin
            errors++;
            $display("FAIL dz_rsp: got %h/%b/%b required %h/%b/%b", rsp_data, rsp_err, rsp_dz, e.data, e.err, e.dz);
        end
        ack();
        send(4'd5, 32'd3, 32'd100);
        wait_rsp();
        e = sbq.pop_front();
        checks++;
        if ({rsp_data, rsp_err, rsp_dz} !== {e.data, e.err, e.dz}) begin
            errors++;
            $display("FAIL rem_rsp: got %h/%b/%b required %h/%b/%b", rsp_data, rsp_err, rsp_dz, e.data, e.err, e.dz);
        end
        ack();
    endtask

    task automatic test_full_fifo();
        int unsigned acc_cyc = 0;
        int unsigned con_cyc = 0;
        for (int i = 0; i < 5; i++) send(4'd2, 32'(i), 32'd10);
        checks++;
        if (cmd_ready !== 1'b0 || count !== CW'(DEPTH)) begin
            errors++;
            $display("FAIL full_ready: cmd_ready=%b count=%0d required 0/%0d", cmd_ready, count, DEPTH);
        end
        fork
            begin
                send(4'd2, 32'd5, 32'd10);
                acc_cyc = cyc;
            end
            begin
                for (int i = 0; i < 6; i++) begin
                    exp_t e;
                    wait_rsp();
                    e = sbq.pop_front();
                    checks++;
                    if (rsp_data !== 32'(10 - i) || rsp_data !== e.data) begin
                        errors++;
                        $display("FAIL full_order[%0d]: got %0d required %0d", i, rsp_data, 10 - i);
                    end
                    ack();
                    if (i == 0) con_cyc = cyc;
                end
            end
        join
        checks++;
        if (!(acc_cyc > con_cyc)) begin
            errors++;
            $display("FAIL full_sixth: accepted at cycle %0d, required after consume at %0d", acc_cyc, con_cyc);
        end
    endtask

    task automatic test_backpressure();
        exp_t e;
        logic [31:0] d0;
        logic stable = 1'b1;
        send(4'd1, 32'd1, 32'd2);
        send(4'd1, 32'd3, 32'd4);
        wait_rsp();
        d0 = rsp_data;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b1 || rsp_data !== d0) stable = 1'b0;
        end
        checks++;
        if (stable !== 1'b1) begin errors++; $display("FAIL bp_stable: response changed while stalled, required stable"); end
        e = sbq.pop_front();
        checks++;
        if (rsp_data !== e.data) begin errors++; $display("FAIL bp_rsp0: got %0d required %0d", rsp_data, e.data); end
        ack();
        checks++;
        if (busy !== 1'b1 || rsp_valid !== 1'b0 || {alu_opcode, alu_a, alu_b} !== {4'd1, 32'd3, 32'd4}) begin
            errors++;
            $display("FAIL bp_issue: busy=%b valid=%b op=%0d a=%0d b=%0d required 1/0/1/3/4",
                     busy, rsp_valid, alu_opcode, alu_a, alu_b);
        end
        wait_rsp();
        e = sbq.pop_front();
        checks++;
        if (rsp_data !== e.data) begin errors++; $display("FAIL bp_rsp1: got %0d required %0d", rsp_data, e.data); end
        ack();
    endtask

    task automatic test_reset_mid();
        logic seen = 1'b0;
        send(4'd1, 32'd10, 32'd20);
        send(4'd1, 32'd11, 32'd21);
        send(4'd1, 32'd12, 32'd22);
        checks++;
        if (busy !== 1'b1 || rsp_valid !== 1'b0 || count !== CW'(2)) begin
            errors++;
            $display("FAIL rmid_pre: busy=%b valid=%b count=%0d required 1/0/2", busy, rsp_valid, count);
        end
        reset = 1'b1;
        cmd_opcode = 4'd1; cmd_a = 32'd1; cmd_b = 32'd1; cmd_valid = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        cmd_valid = 1'b0;
        sbq.delete();
        checks++;
        if (count !== '0 || rsp_valid !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1 || alu_opcode !== 4'd0) begin
            errors++;
            $display("FAIL rmid_state: count=%0d valid=%b busy=%b ready=%b op=%0d required 0/0/0/1/0",
                     count, rsp_valid, busy, cmd_ready, alu_opcode);
        end
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0 || busy !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin errors++; $display("FAIL rmid_quiet: activity after reset, required none"); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, required finish");
        $fatal(1);
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_add();
        test_carry();
        test_divzero();
        test_full_fifo();
        test_backpressure();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
